// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    RC_OK       = 2'd0,
    RC_MISALIGN = 2'd1,
    RC_ILLEGAL  = 2'd2,
    RC_TIMEOUT  = 2'd3
  } resp_code_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal width codes take priority over alignment faults.
  function automatic resp_code_t classify(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
    if (!(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && f3[2]))
      return RC_ILLEGAL;
    if ((f3 == F3_H || f3 == F3_HU) && off[0])
      return RC_MISALIGN;
    if (f3 == F3_W && off != 2'b00)
      return RC_MISALIGN;
    return RC_OK;
  endfunction

  function automatic logic [3:0] byte_sel(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << {off[1], 1'b0};
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Word-addressed data memory bus between the LSU and memory.
interface memory_bus;
  logic [31:2] addr;
  logic [31:0] dataD;
  logic [31:0] dataQ;
  logic        read;
  logic        write;
  logic        ready;
  logic [3:0]  byteSel;

  modport master (output addr, dataD, read, write, byteSel,
                  input  dataQ, ready);
  modport slave  (input  addr, dataD, read, write, byteSel,
                  output dataQ, ready);
endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational lane select and sign/zero extension of load data.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] dataq,
  output logic [31:0] rdata
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel  = dataq[7:0];
    hsel  = dataq[15:0];
    rdata = dataq;
    case (off)
      2'd1:    bsel = dataq[15:8];
      2'd2:    bsel = dataq[23:16];
      2'd3:    bsel = dataq[31:24];
      default: bsel = dataq[7:0];
    endcase
    if (off[1]) hsel = dataq[31:16];
    case (funct3)
      F3_B:    rdata = {{24{bsel[7]}}, bsel};
      F3_BU:   rdata = {24'h0, bsel};
      F3_H:    rdata = {{16{hsel[15]}}, hsel};
      F3_HU:   rdata = {16'h0, hsel};
      default: rdata = dataq;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, IDLE -> BUSY -> RESP,
// with bus timeout and alignment/width error reporting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       resp_code,
  memory_bus.master        dbus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [TAG_W-1:0] tag_q;
  resp_code_t       acc_code;
  logic [31:0]      ext_rdata;

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    acc_code = classify(req_we, req_funct3, req_addr[1:0]);
  end

  lsu_load_ext u_load_ext (
    .funct3 (f3_q),
    .off    (off_q),
    .dataq  (dbus.dataQ),
    .rdata  (ext_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      tag_q        <= '0;
      dbus.addr    <= '0;
      dbus.dataD   <= '0;
      dbus.byteSel <= '0;
      dbus.read    <= 1'b0;
      dbus.write   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_tag     <= '0;
      resp_code    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (acc_code != RC_OK) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_code  <= acc_code;
              resp_rdata <= '0;
              resp_tag   <= req_tag;
            end else begin
              state        <= ST_BUSY;
              cnt          <= '0;
              f3_q         <= req_funct3;
              off_q        <= req_addr[1:0];
              we_q         <= req_we;
              tag_q        <= req_tag;
              dbus.addr    <= req_addr[31:2];
              dbus.byteSel <= byte_sel(req_funct3, req_addr[1:0]);
              dbus.dataD   <= store_data(req_funct3, req_wdata);
              dbus.read    <= ~req_we;
              dbus.write   <= req_we;
            end
          end
        end
        ST_BUSY: begin
          // ready on the expiry edge still counts as a successful transfer
          if (dbus.ready) begin
            state      <= ST_RESP;
            dbus.read  <= 1'b0;
            dbus.write <= 1'b0;
            resp_valid <= 1'b1;
            resp_code  <= RC_OK;
            resp_rdata <= we_q ? '0 : ext_rdata;
            resp_tag   <= tag_q;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= ST_RESP;
            dbus.read  <= 1'b0;
            dbus.write <= 1'b0;
            resp_valid <= 1'b1;
            resp_code  <= RC_TIMEOUT;
            resp_rdata <= '0;
            resp_tag   <= tag_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the number of BUSY cycles without dbus.ready before a transfer is aborted.
REQ-002 SHALL have parameter TAG_W, default 5, meaning the width of the destination tag carried with a request.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req_valid  in  1  pipeline request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_tag  in  TAG_W  destination tag, returned unchanged.
REQ-012 resp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_tag  out  TAG_W  tag of the completed request.
REQ-015 resp_code  out  2  completion code: 0 OK, 1 misaligned, 2 illegal funct3, 3 timeout.
REQ-016 dbus  memory_bus.master  --  data memory port (addr[31:2], dataD, dataQ, read, write, ready, byteSel).

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE, with IDLE -> RESP used directly on error.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&req_ready.
REQ-019 SHALL check at acceptance: H/HU with addr[0]=1, or W with addr[1:0]!=0, gives code 1; funct3 011/110/111, or a store with funct3[2]=1, gives code 2; either error goes to RESP with no bus access.
REQ-020 SHALL, on a legal accept, register dbus.addr=req_addr[31:2] and byteSel (B: 0001<<addr[1:0]; H: 0011<<{addr[1],1'b0}; W: 1111); byteSel is driven for loads too.
REQ-021 SHALL register dbus.dataD as B: {4{wdata[7:0]}}; H: {2{wdata[15:0]}}; W: wdata.
REQ-022 SHALL assert exactly one of read/write from the cycle after accept and hold addr/dataD/byteSel/read/write stable until the edge that samples ready=1.
REQ-023 SHALL, on the edge sampling ready=1 in BUSY, capture dataQ, deassert read/write, and enter RESP; minimum latency is accept edge N, bus active cycle N+1, resp_valid in cycle N+2.
REQ-024 SHALL extract a load as the byte at offset addr[1:0] or the half at addr[1], sign-extended for B/H and zero-extended for BU/HU; W passes dataQ through.
REQ-025 SHALL count BUSY cycles; on reaching TIMEOUT with ready=0 it SHALL deassert read/write and respond with code 3.
REQ-026 SHALL treat ready=1 on the same edge as timeout expiry as success (code 0).
REQ-027 SHALL ignore dbus.ready while in IDLE or RESP.
REQ-028 SHALL hold resp_valid for exactly one cycle (RESP); req_ready returns to 1 in the following cycle.

Reset
REQ-029 SHALL, on rst assertion at any time including mid-transfer, immediately force: state IDLE, read=0, write=0, addr=0, dataD=0, byteSel=0, resp_valid=0, resp_rdata=0, resp_tag=0, resp_code=0, timeout counter=0.
REQ-030 SHALL drive req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the FSM state enum, funct3 constants, and resp_code enum in shared package lsu_pkg.
REQ-032 SHALL place load extraction and sign/zero extension in combinational sub-module lsu_load_ext.

Verification
REQ-033 Store: SB addr 0x1003, wdata 0xA5 -> byteSel 1000, dataD 0xA5A5A5A5, addr 0x400; with ready on the first cycle, resp code 0 two cycles after accept.
REQ-034 Load: LH addr 0x2002, dataQ 0x8001_1234 -> resp_rdata 0xFFFF8001; the same request as LHU -> 0x00008001.
REQ-035 Errors: LW addr 0x3001 -> code 1, read/write never asserted; SW with funct3 110 -> code 2.
REQ-036 Wait/timeout: ready held low 5 cycles then high -> addr/read stable all 6 cycles, code 0; ready never high with TIMEOUT=8 -> code 3 after 8 BUSY cycles; ready high on cycle 8 -> code 0.
REQ-037 Reset: assert rst mid-BUSY -> read/write low before the next edge, no resp_valid, req_ready=1 after release.
REQ-038 Throughput: back-to-back req_valid with 1-cycle ready -> one accept per 3 cycles, tags returned in order.
